// File: rtl/nn_gpio_pkg.sv
// Shared constants and helpers for the nn_gpio_keyled GPIO peripheral.
package nn_gpio_pkg;

  // Byte offsets of the register window (bits [1:0] are never decoded).
  localparam int LED_OUT_OFS   = 'h0;
  localparam int KEY_STATE_OFS = 'h4;
  localparam int KEY_EDGE_OFS  = 'h8;
  localparam int IRQ_EN_OFS    = 'hC;

  // Width of a debounce counter that must hold values 0..cyc-1.
  function automatic int cnt_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/nn_debounce.sv
// One key input: two-flop synchroniser, stability counter and debounced level.
module nn_debounce
  import nn_gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Count consecutive cycles the synchronised input disagrees with the level;
  // the level flips on the cycle the count would reach DEBOUNCE_CYC.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    rise    = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise    = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any count in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/nn_gpio_keyled.sv
// Memory-mapped GPIO: debounced keys with sticky edge flags and IRQ, plus LEDs.
module nn_gpio_keyled
  import nn_gpio_pkg::*;
#(
  parameter int KEY_W        = 2,
  parameter int LED_W        = 8,
  parameter int DEBOUNCE_CYC = 4,
  parameter int ADDR_W       = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [KEY_W-1:0]  KEY,
  output logic [LED_W-1:0]  LED,
  input  logic              SEL,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic [31:0]       RDATA,
  output logic              IRQ
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [WORD_W-1:0] W_LED   = WORD_W'(LED_OUT_OFS   >> 2);
  localparam logic [WORD_W-1:0] W_STATE = WORD_W'(KEY_STATE_OFS >> 2);
  localparam logic [WORD_W-1:0] W_EDGE  = WORD_W'(KEY_EDGE_OFS  >> 2);
  localparam logic [WORD_W-1:0] W_EN    = WORD_W'(IRQ_EN_OFS    >> 2);

  logic [KEY_W-1:0]  key_state, key_rise;
  logic [LED_W-1:0]  led_q, led_d;
  logic [KEY_W-1:0]  kedge_q, kedge_d;
  logic [KEY_W-1:0]  irq_en_q, irq_en_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic [KEY_W-1:0]  kclr;
  logic [31:0]       rd_mux;
  logic [WORD_W-1:0] word;
  logic              wr, rd;
  logic              unused_bits;

  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    nn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk     (CLK),
      .rst_n   (RST_N),
      .key_raw (KEY[i]),
      .level   (key_state[i]),
      .rise    (key_rise[i])
    );
  end

  assign word        = ADDR[ADDR_W-1:2];
  assign wr          = SEL & WE;
  assign rd          = SEL & ~WE;
  assign unused_bits = ^{ADDR[1:0], WDATA};

  // Read mux over current register contents; unmapped words read zero.
  always_comb begin
    rd_mux = '0;
    case (word)
      W_LED:   rd_mux[LED_W-1:0] = led_q;
      W_STATE: rd_mux[KEY_W-1:0] = key_state;
      W_EDGE:  rd_mux[KEY_W-1:0] = kedge_q;
      W_EN:    rd_mux[KEY_W-1:0] = irq_en_q;
      default: rd_mux = '0;
    endcase
  end

  // Register writes, edge capture (a new rise beats a same-cycle clear), IRQ and read data.
  always_comb begin
    led_d    = led_q;
    irq_en_d = irq_en_q;
    kclr     = '0;
    if (wr && word == W_LED) led_d    = WDATA[LED_W-1:0];
    if (wr && word == W_EN)  irq_en_d = WDATA[KEY_W-1:0];
    if (wr && word == W_EDGE) kclr    = WDATA[KEY_W-1:0];
    kedge_d = (kedge_q & ~kclr) | key_rise;
    irq_d   = |(kedge_q & irq_en_q);
    rdata_d = rd ? rd_mux : rdata_q;
  end

  // Register bank.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_q    <= '0;
      kedge_q  <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      kedge_q  <= kedge_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign LED   = led_q;
  assign RDATA = rdata_q;
  assign IRQ   = irq_q;

endmodule

// File: tb/tb_nn_gpio_keyled.sv
// Self-checking bench for nn_gpio_keyled: cycle model plus directed literal checks.
module tb_nn_gpio_keyled;

  localparam int KEY_W  = 2;
  localparam int LED_W  = 8;
  localparam int D      = 4;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [KEY_W-1:0]  KEY = '0;
  logic [LED_W-1:0]  LED;
  logic              SEL = 1'b0;
  logic              WE = 1'b0;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [31:0]       WDATA = '0;
  logic [31:0]       RDATA;
  logic              IRQ;

  int n_pass = 0;
  int n_total = 0;

  nn_gpio_keyled #(.KEY_W(KEY_W), .LED_W(LED_W), .DEBOUNCE_CYC(D), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .KEY(KEY), .LED(LED), .SEL(SEL), .WE(WE),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .IRQ(IRQ)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: raw key history; a key level flips once the delayed
  // (synchronised) sample has disagreed with it for D consecutive edges.
  logic [LED_W-1:0] m_led = '0;
  logic [KEY_W-1:0] m_state = '0, m_edge = '0, m_en = '0;
  logic [31:0]      m_rdata = '0;
  logic             m_irq = 1'b0;
  logic [KEY_W-1:0] hist [0:D];

  initial begin
    logic [KEY_W-1:0] nstate, rise, clr;
    logic [31:0] rv;
    int w;
    bit all_diff;
    for (int k = 0; k <= D; k++) hist[k] = '0;
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_led = '0; m_state = '0; m_edge = '0; m_en = '0; m_rdata = '0; m_irq = 1'b0;
        for (int k = 0; k <= D; k++) hist[k] = '0;
      end else begin
        w = int'(ADDR) / 4;
        case (w)
          0: rv = 32'(m_led);
          1: rv = 32'(m_state);
          2: rv = 32'(m_edge);
          3: rv = 32'(m_en);
          default: rv = 32'h0;
        endcase
        nstate = m_state;
        rise = '0;
        for (int i = 0; i < KEY_W; i++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= D; k++) if (hist[k][i] == m_state[i]) all_diff = 1'b0;
          if (all_diff) begin
            nstate[i] = ~m_state[i];
            rise[i] = ~m_state[i];
          end
        end
        clr = '0;
        m_irq = |(m_edge & m_en);
        if (SEL && !WE) m_rdata = rv;
        if (SEL && WE) begin
          if (w == 0) m_led = WDATA[LED_W-1:0];
          if (w == 2) clr = WDATA[KEY_W-1:0];
          if (w == 3) m_en = WDATA[KEY_W-1:0];
        end
        m_edge = (m_edge & ~clr) | rise;
        m_state = nstate;
        for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
        hist[0] = KEY;
      end
    end
  end

  // Every-cycle comparison of visible outputs against the model.
  initial forever begin
    @(negedge CLK);
    chk("model_led", 32'(LED), 32'(m_led));
    chk("model_rdata", RDATA, m_rdata);
    chk("model_irq", 32'(IRQ), 32'(m_irq));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    SEL = 1'b1; WE = 1'b1; ADDR = a; WDATA = d;
    @(negedge CLK);
    SEL = 1'b0; WE = 1'b0; WDATA = '0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a);
    SEL = 1'b1; WE = 1'b0; ADDR = a;
    @(negedge CLK);
    SEL = 1'b0;
  endtask

  initial begin
    // Reset held with both keys high.
    KEY = 2'b11;
    cyc(3);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    RST_N = 1'b1;
    SEL = 1'b1; WE = 1'b0; ADDR = 5'h4;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      chk($sformatf("rst_state_e%0d", k), RDATA, (k == 7) ? 32'h3 : 32'h0);
    end
    SEL = 1'b0;
    bus_rd(5'h8);
    chk("rst_edge", RDATA, 32'h3);
    KEY = 2'b00;
    cyc(8);
    bus_wr(5'h8, 32'h3);
    bus_rd(5'h8);
    chk("w1c_all", RDATA, 32'h0);

    // LED write with bits above LED_W ignored.
    bus_wr(5'h0, 32'h1A5);
    chk("led_write", 32'(LED), 32'hA5);
    bus_rd(5'h0);
    chk("led_read", RDATA, 32'hA5);

    // Short glitch must not be accepted.
    KEY = 2'b01;
    cyc(3);
    KEY = 2'b00;
    cyc(8);
    bus_rd(5'h4);
    chk("glitch_state", RDATA, 32'h0);
    bus_rd(5'h8);
    chk("glitch_edge", RDATA, 32'h0);

    // Long press is accepted.
    KEY = 2'b01;
    cyc(10);
    bus_rd(5'h4);
    chk("press_state", RDATA, 32'h1);
    bus_rd(5'h8);
    chk("press_edge", RDATA, 32'h1);

    // Interrupt path.
    bus_wr(5'h8, 32'h1);
    bus_wr(5'hC, 32'h1);
    KEY = 2'b00;
    cyc(8);
    KEY = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      chk($sformatf("irq_e%0d", k), 32'(IRQ), (k == 7) ? 32'h1 : 32'h0);
    end
    bus_wr(5'h8, 32'h1);
    chk("irq_hold_after_clr", 32'(IRQ), 32'h1);
    cyc(1);
    chk("irq_drop", 32'(IRQ), 32'h0);
    KEY = 2'b00;
    cyc(10);
    bus_rd(5'h8);
    chk("release_no_edge", RDATA, 32'h0);
    chk("release_irq", 32'(IRQ), 32'h0);

    // Clear of bit 1 on the same edge KEY_STATE[1] rises: set wins.
    KEY = 2'b10;
    cyc(5);
    bus_wr(5'h8, 32'h2);
    bus_rd(5'h8);
    chk("collision_edge", RDATA, 32'h2);

    // Read-only and unmapped writes.
    bus_wr(5'h4, 32'hFFFF_FFFF);
    bus_wr(5'h10, 32'hFFFF_FFFF);
    bus_rd(5'h4);
    chk("ro_state", RDATA, 32'h2);
    bus_rd(5'h10);
    chk("unmapped_rd", RDATA, 32'h0);
    bus_rd(5'h1);
    chk("led_low_bits_ignored", RDATA, 32'hA5);
    bus_rd(5'hC);
    chk("irq_en_rd", RDATA, 32'h1);

    // Reset in the middle of a debounce with the key held through release.
    KEY = 2'b00;
    cyc(8);
    bus_wr(5'h8, 32'h3);
    KEY = 2'b01;
    cyc(3);
    RST_N = 1'b0;
    cyc(1);
    RST_N = 1'b1;
    cyc(5);
    bus_rd(5'h8);
    chk("midrst_edge_pending", RDATA, 32'h0);
    cyc(2);
    bus_rd(5'h8);
    chk("midrst_edge", RDATA, 32'h1);
    bus_rd(5'h0);
    chk("midrst_led", RDATA, 32'h0);
    chk("midrst_irq", 32'(IRQ), 32'h0);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nn_gpio_keyled.md
Name: nn_gpio_keyled

Overview:
- Parametrised memory-mapped GPIO peripheral for the nnRvSoc core.
- Replaces direct KEY/LED wiring with:
  - N debounced key inputs, each with sticky rising-edge flags and a maskable interrupt.
  - M software-writable LED outputs.
- Sits on the SoC's simple single-master data bus beside RAM.
- Drives the board LED pins and the core's external interrupt line.

Parameters:
- KEY_W, 2, number of key inputs (1..32)
- LED_W, 8, number of LED outputs (1..32)
- DEBOUNCE_CYC, 4, consecutive stable cycles required to accept a key change (>=1)
- ADDR_W, 4, byte-address width of the register window

Ports:
- CLK  in  1  system clock, rising-edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- KEY  in  KEY_W  raw asynchronous key pins
- LED  out  LED_W  LED pins, equal to LED_OUT register
- SEL  in  1  bus select for this peripheral
- WE  in  1  write enable (valid with SEL)
- ADDR  in  ADDR_W  byte address; bits [1:0] ignored
- WDATA  in  32  write data
- RDATA  out  32  read data, registered
- IRQ  out  1  level interrupt, registered

Behaviour:
- Reset (RST_N low, async), all cleared while asserted:
  - LED=0, RDATA=0, IRQ=0.
  - Sync flops 0, debounce counters 0, KEY_STATE 0, KEY_EDGE 0, IRQ_EN 0.
- Register map, word offsets; unimplemented bits read 0:
  - 0x0 LED_OUT: RW, [LED_W-1:0].
  - 0x4 KEY_STATE: RO, debounced key levels; writes ignored.
  - 0x8 KEY_EDGE: sticky rising-edge flags; write-1-to-clear.
  - 0xC IRQ_EN: RW, per-key interrupt mask.
  - Unmapped offsets: read 0, writes ignored.
- Input path per key:
  - Two-flop synchroniser feeds the debouncer.
  - The counter increments on each edge where the synchronised value differs from KEY_STATE.
  - The counter resets to 0 on any edge where they match.
  - When the counter would reach DEBOUNCE_CYC, KEY_STATE takes the synchronised value and the counter returns to 0.
  - A steady input change is therefore visible in KEY_STATE exactly DEBOUNCE_CYC+2 rising edges after it is first sampled.
  - A glitch shorter than DEBOUNCE_CYC synchronised cycles never changes KEY_STATE.
- Edge capture:
  - A 0->1 transition of KEY_STATE[i] sets KEY_EDGE[i] on the same edge KEY_STATE updates.
  - 1->0 transitions set nothing.
  - A set and a W1C clear of the same bit on the same edge: set wins, bit stays 1.
- Bus protocol:
  - Write: SEL&WE sampled on a rising edge; the register updates on that edge.
  - Read: SEL&!WE on edge k; RDATA holds the selected value as of before edge k, valid after edge k, i.e. 1-cycle latency.
  - RDATA holds its value when not reading.
- LED: registered; updates on the write edge; no glitches between writes.
- IRQ: registered OR over (KEY_EDGE & IRQ_EN), one cycle behind the flags.
  - Clearing the last pending enabled flag deasserts IRQ one edge after the clear.
- Widths: WDATA bits above KEY_W or LED_W are ignored on write.
- Reset mid-operation:
  - Any in-progress debounce count is discarded.
  - A key held high through reset release produces a KEY_EDGE after DEBOUNCE_CYC+2 edges.

Decomposition:
- Package nn_gpio_pkg holds:
  - Register offset constants: LED_OUT_OFS, KEY_STATE_OFS, KEY_EDGE_OFS, IRQ_EN_OFS.
  - A function computing the counter width from DEBOUNCE_CYC.
- One sub-module, nn_debounce:
  - Contains the synchroniser, counter and stable level.
  - Has a rise-pulse output.
  - Instantiated KEY_W times by generate.
- Register file, bus decode and IRQ logic stay in nn_gpio_keyled.

Test Plan:
- Reset: hold RST_N low 3 cycles with KEY=2'b11 -> LED=0, RDATA=0, IRQ=0. After release, read 0x4 returns 0 until edge 6, then 0x3.
- LED write: write 0x1A5 to 0x0 with LED_W=8 -> LED=8'hA5 on the write edge; read 0x0 next cycle -> RDATA=0x000000A5.
- Glitch: KEY[0] high for 3 cycles, DEBOUNCE_CYC=4 -> KEY_STATE and KEY_EDGE stay 0. Holding it high for 10 cycles -> KEY_STATE[0]=1 at edge 6 and KEY_EDGE=0x1.
- Interrupt: write IRQ_EN=0x1, press KEY[0] -> IRQ=1 one edge after KEY_EDGE[0] sets. Write 0x1 to 0x8 -> IRQ=0 one edge later. Release KEY[0] -> no new edge.
- Set/clear collision: time a W1C of 0x2 to coincide with KEY_STATE[1] rising -> KEY_EDGE[1] reads 1 afterwards.
- Unmapped/RO: write 0xFFFFFFFF to 0x4 and to 0x10 alias-free offsets -> KEY_STATE unchanged; a read of unmapped offset returns 0.
